// File: rtl/neuron_backprop_seq.sv
// Back-propagation and weight-update engine for one sigmoid neuron.
// Bias and weights are updated one per cycle through a single shared fixed-point multiplier.
module neuron_backprop_seq #(
  parameter int N_IN = 3,
  parameter int FRAC = 16,
  localparam int IW = $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_hidden,
  input  logic [31:0]          o,
  input  logic [31:0]          target,
  input  logic [31:0]          err_in,
  input  logic [31:0]          step,
  input  logic [N_IN*32-1:0]   x_flat,
  input  logic                 load_en,
  input  logic [IW-1:0]        load_idx,
  input  logic [31:0]          load_data,
  output logic [31:0]          bias,
  output logic [N_IN*32-1:0]   w_flat,
  output logic [31:0]          delta_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [31:0] ONE = 32'(64'd1 << FRAC);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DERIV = 3'd1,
    DELTA = 3'd2,
    SCALE = 3'd3,
    UPD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_r;
  logic [31:0]         o_r, target_r, err_r, step_r, d_r, g_r;
  logic [N_IN*32-1:0]  x_r;
  logic                hid_r;
  logic [IW-1:0]       k_r;
  logic [31:0]         x_sel_s, cur_sel_s, upd_val_s;

  // Signed fixed-point product, floor-truncated back to 32 bits.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ae, be, p;
    ae = 64'(signed'(a));
    be = 64'(signed'(b));
    p  = ae * be;
    return p[FRAC+31:FRAC];
  endfunction

  // Select the operand pair for the current update index (k=0 is bias with x=one).
  always_comb begin
    x_sel_s   = ONE;
    cur_sel_s = bias;
    for (int i = 0; i < N_IN; i++) begin
      x_sel_s   = (k_r == IW'(i + 1)) ? x_r[32*i +: 32]    : x_sel_s;
      cur_sel_s = (k_r == IW'(i + 1)) ? w_flat[32*i +: 32] : cur_sel_s;
    end
    upd_val_s = cur_sel_s - fmul(g_r, x_sel_s);
  end

  // Training-step FSM with registered outputs and parameter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bias      <= 32'd0;
      w_flat    <= '0;
      delta_out <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      o_r       <= 32'd0;
      target_r  <= 32'd0;
      err_r     <= 32'd0;
      step_r    <= 32'd0;
      x_r       <= '0;
      hid_r     <= 1'b0;
      d_r       <= 32'd0;
      g_r       <= 32'd0;
      k_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (load_en) begin
            if (load_idx == '0) bias <= load_data;
            for (int i = 0; i < N_IN; i++) begin
              if (load_idx == IW'(i + 1)) w_flat[32*i +: 32] <= load_data;
            end
          end else if (start) begin
            o_r      <= o;
            target_r <= target;
            err_r    <= err_in;
            step_r   <= step;
            x_r      <= x_flat;
            hid_r    <= is_hidden;
            busy     <= 1'b1;
            state_r  <= DERIV;
          end
        end
        DERIV: begin
          d_r     <= fmul(o_r, ONE - o_r);
          state_r <= DELTA;
        end
        DELTA: begin
          delta_out <= fmul(hid_r ? err_r : (o_r - target_r), d_r);
          state_r   <= SCALE;
        end
        SCALE: begin
          g_r     <= fmul(step_r, delta_out);
          k_r     <= '0;
          state_r <= UPD;
        end
        UPD: begin
          if (k_r == '0) bias <= upd_val_s;
          for (int i = 0; i < N_IN; i++) begin
            if (k_r == IW'(i + 1)) w_flat[32*i +: 32] <= upd_val_s;
          end
          if (k_r == IW'(N_IN)) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            k_r <= k_r + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_backprop_seq.sv
// Directed self-checking bench for neuron_backprop_seq with hand-computed fixed-point results.
module tb_neuron_backprop_seq;

  localparam int N_IN = 3;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              reset, start, is_hidden, load_en;
  logic [31:0]       o, target, err_in, step, load_data;
  logic [N_IN*32-1:0] x_flat;
  logic [IW-1:0]     load_idx;
  logic [31:0]       bias, delta_out;
  logic [N_IN*32-1:0] w_flat;
  logic              busy, done;

  int checks = 0;
  int errors = 0;
  int lat;

  neuron_backprop_seq #(.N_IN(N_IN), .FRAC(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_hidden(is_hidden),
    .o(o), .target(target), .err_in(err_in), .step(step), .x_flat(x_flat),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .bias(bias), .w_flat(w_flat), .delta_out(delta_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [31:0] data);
    load_en = 1'b1; load_idx = idx; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  // Pulse start and count cycles until done, bounded.
  task automatic run_step(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_weights(input string tag, input logic [31:0] b,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    check({tag, " bias"}, bias, b);
    check({tag, " w0"}, w_flat[31:0], w0);
    check({tag, " w1"}, w_flat[63:32], w1);
    check({tag, " w2"}, w_flat[95:64], w2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_hidden = 1'b0; load_en = 1'b0;
    o = 32'd0; target = 32'd0; err_in = 32'd0; step = 32'd0;
    load_data = 32'd0; load_idx = '0; x_flat = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check_weights("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    check("reset delta", delta_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);

    load(2'd0, 32'h0000_0000);
    load(2'd1, 32'h0000_8000);
    load(2'd2, 32'h0000_8000);
    load(2'd3, 32'h0000_0000);
    check_weights("preload", 32'd0, 32'h8000, 32'h8000, 32'd0);

    // Output-layer step; inputs disturbed and start/load toggled mid-step.
    o = 32'h0000_C000; target = 32'h0001_0000; step = 32'h0001_0000;
    x_flat = {32'h0001_0000, 32'h0000_0000, 32'h0002_0000};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("busy c%0d", c), {31'd0, busy}, 32'd1);
      check($sformatf("done c%0d", c), {31'd0, done}, (c == 8) ? 32'd1 : 32'd0);
      if (c == 2) begin
        o = 32'h0000_4000; x_flat = {N_IN{32'h0005_0000}};
        start = 1'b1; load_en = 1'b1; load_idx = 2'd1; load_data = 32'hDEAD_BEEF;
      end
      if (c == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
      if (c == 5) begin
        check("mid bias", bias, 32'h0000_0C00);
        check("mid w0", w_flat[31:0], 32'h0000_8000);
      end
      tick();
    end
    check("post busy", {31'd0, busy}, 32'd0);
    check("post done", {31'd0, done}, 32'd0);
    check("out delta", delta_out, 32'hFFFF_F400);
    check_weights("out", 32'h0000_0C00, 32'h0000_9800, 32'h0000_8000, 32'h0000_0C00);
    tick(); tick();
    check("no extra step", {31'd0, busy}, 32'd0);

    // Hidden mode with step=0: floor truncation of delta, weights untouched.
    is_hidden = 1'b1; err_in = 32'hFFFF_FFFF; o = 32'h0000_8000; step = 32'd0;
    run_step(lat);
    check("hidden latency", lat, 32'd8);
    check("hidden delta", delta_out, 32'hFFFF_FFFF);
    check_weights("step0", 32'h0000_0C00, 32'h0000_9800, 32'h0000_8000, 32'h0000_0C00);
    tick();

    // Load wins over start in the same IDLE cycle.
    load_en = 1'b1; start = 1'b1; load_idx = 2'd3; load_data = 32'h1234_5678;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("load prio busy", {31'd0, busy}, 32'd0);
    check("load prio w2", w_flat[95:64], 32'h1234_5678);
    tick();
    check("load prio busy2", {31'd0, busy}, 32'd0);

    // Reset during UPD aborts the step and clears the weights.
    is_hidden = 1'b0; o = 32'h0000_C000; target = 32'h0001_0000; step = 32'h0001_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort delta", delta_out, 32'd0);
    check_weights("abort", 32'd0, 32'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
